irl_tb_meter: RTL and testbench

Token-bucket metering and refill engine for the ingress rate limiter. Sits directly upstream of the IRL memory block and is the sole owner of its token-bucket and fill-source read/write ports. Per packet it performs a read-modify-write of the flow's CIR/EIR buckets and returns a colour. In idle cycles it sweeps all flows and adds each flow's fill increments with saturation.

---
 rtl/irl_tb_meter.sv | 174 +++++++++++++++++
 tb/tb_irl_tb_meter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/irl_tb_meter.sv
// irl_tb_meter: per-packet token-bucket metering (CIR/EIR) plus saturating refill sweep over all flows.
// Optional macro IRL_COLOR_AWARE_EN adds meter_color_in for colour-aware metering.
`ifndef FLOW_VALUE_DEPTH_NBITS
`define FLOW_VALUE_DEPTH_NBITS 4
`endif
`ifndef CIR_NBITS
`define CIR_NBITS 16
`endif
`ifndef EIR_NBITS
`define EIR_NBITS 16
`endif

module irl_tb_meter #(
  parameter int DEPTH_NBITS  = `FLOW_VALUE_DEPTH_NBITS,
  parameter int CIR_TB_NBITS = `CIR_NBITS + 2,
  parameter int EIR_TB_NBITS = `EIR_NBITS + 2,
  parameter int INC_NBITS    = 16,
  parameter int LEN_NBITS    = 14
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 refill_tick,
  input  logic                                 meter_req,
  input  logic [DEPTH_NBITS-1:0]               meter_flow_id,
  input  logic [LEN_NBITS-1:0]                 meter_len,
`ifdef IRL_COLOR_AWARE_EN
  input  logic [1:0]                           meter_color_in,
`endif
  output logic                                 meter_valid,
  output logic [1:0]                           meter_color,
  output logic                                 sweep_busy,
  output logic                                 sweep_overrun,
  output logic                                 token_bucket_rd,
  output logic [DEPTH_NBITS-1:0]               token_bucket_raddr,
  input  logic                                 token_bucket_ack,
  input  logic [CIR_TB_NBITS+EIR_TB_NBITS-1:0] token_bucket_rdata,
  output logic                                 token_bucket_wr,
  output logic [DEPTH_NBITS-1:0]               token_bucket_waddr,
  output logic [CIR_TB_NBITS+EIR_TB_NBITS-1:0] token_bucket_wdata,
  output logic                                 fill_tb_src_rd,
  output logic [DEPTH_NBITS-1:0]               fill_tb_src_raddr,
  input  logic                                 fill_tb_src_ack,
  input  logic [2*INC_NBITS-1:0]               fill_tb_src_rdata
);

  localparam int TBW = CIR_TB_NBITS + EIR_TB_NBITS;

  typedef enum logic {IDLE, SWEEP} state_e;
  typedef enum logic [1:0] {GREEN = 2'd0, YELLOW = 2'd1, RED = 2'd2} color_e;

  state_e                  state;
  logic [DEPTH_NBITS-1:0]  ptr;
  logic                    slot_meter, slot_refill;

  logic                    s1_meter, s1_refill;
  logic [DEPTH_NBITS-1:0]  s1_addr;
  logic [LEN_NBITS-1:0]    s1_len;
  logic [1:0]              s1_cin;

  logic                    byp_valid;
  logic [DEPTH_NBITS-1:0]  byp_addr;
  logic [TBW-1:0]          byp_data;

  logic [TBW-1:0]          cur;
  logic [CIR_TB_NBITS-1:0] cir, new_cir, len_c;
  logic [EIR_TB_NBITS-1:0] eir, new_eir, len_e;
  logic [CIR_TB_NBITS:0]   cir_sum;
  logic [EIR_TB_NBITS:0]   eir_sum;
  logic                    try_cir, try_eir, meter_done, wr;
  color_e                  s1_color;

  // Slot arbitration: a meter request always wins; the sweep pointer only moves on refill slots.
  always_comb begin
    slot_meter         = meter_req;
    slot_refill        = !meter_req && (state == SWEEP);
    token_bucket_rd    = slot_meter || slot_refill;
    token_bucket_raddr = meter_req ? meter_flow_id : ptr;
    fill_tb_src_rd     = slot_refill;
    fill_tb_src_raddr  = ptr;
    sweep_busy         = (state == SWEEP);
  end

  always_comb begin
`ifdef IRL_COLOR_AWARE_EN
    try_cir = (s1_cin != YELLOW) && (s1_cin != RED);
    try_eir = (s1_cin != RED);
`else
    try_cir = 1'b1;
    try_eir = (s1_cin == s1_cin);
`endif
    // Last cycle's write-back supersedes RAM data that may predate it.
    cur        = (byp_valid && byp_addr == s1_addr) ? byp_data : token_bucket_rdata;
    cir        = cur[TBW-1:EIR_TB_NBITS];
    eir        = cur[EIR_TB_NBITS-1:0];
    cir_sum    = {1'b0, cir} + (CIR_TB_NBITS+1)'(fill_tb_src_rdata[2*INC_NBITS-1:INC_NBITS]);
    eir_sum    = {1'b0, eir} + (EIR_TB_NBITS+1)'(fill_tb_src_rdata[INC_NBITS-1:0]);
    len_c      = CIR_TB_NBITS'(s1_len);
    len_e      = EIR_TB_NBITS'(s1_len);
    new_cir    = cir;
    new_eir    = eir;
    s1_color   = GREEN;
    wr         = 1'b0;
    meter_done = s1_meter && token_bucket_ack;
    if (s1_refill && token_bucket_ack && fill_tb_src_ack) begin
      new_cir = cir_sum[CIR_TB_NBITS] ? '1 : cir_sum[CIR_TB_NBITS-1:0];
      new_eir = eir_sum[EIR_TB_NBITS] ? '1 : eir_sum[EIR_TB_NBITS-1:0];
      wr      = 1'b1;
    end else if (meter_done) begin
      if (try_cir && cir >= len_c) begin
        new_cir = cir - len_c;
        wr      = 1'b1;
      end else if (try_eir && eir >= len_e) begin
        new_eir  = eir - len_e;
        s1_color = YELLOW;
        wr       = 1'b1;
      end else begin
        s1_color = RED;
      end
    end
    token_bucket_wr    = wr;
    token_bucket_waddr = s1_addr;
    token_bucket_wdata = {new_cir, new_eir};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= '0;
      sweep_overrun <= 1'b0;
      s1_meter      <= 1'b0;
      s1_refill     <= 1'b0;
      s1_addr       <= '0;
      s1_len        <= '0;
      s1_cin        <= '0;
      byp_valid     <= 1'b0;
      byp_addr      <= '0;
      byp_data      <= '0;
      meter_valid   <= 1'b0;
      meter_color   <= GREEN;
    end else begin
      s1_meter    <= slot_meter;
      s1_refill   <= slot_refill;
      s1_addr     <= token_bucket_raddr;
      s1_len      <= meter_len;
`ifdef IRL_COLOR_AWARE_EN
      s1_cin      <= meter_color_in;
`else
      s1_cin      <= GREEN;
`endif
      byp_valid   <= wr;
      byp_addr    <= s1_addr;
      byp_data    <= {new_cir, new_eir};
      meter_valid <= meter_done;
      meter_color <= s1_color;
      case (state)
        IDLE: begin
          if (refill_tick) begin
            state <= SWEEP;
            ptr   <= '0;
          end
        end
        SWEEP: begin
          if (refill_tick) sweep_overrun <= 1'b1;
          if (slot_refill) begin
            ptr <= ptr + DEPTH_NBITS'(1);
            if (ptr == '1) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irl_tb_meter.sv
// Bench for irl_tb_meter: RAM models, a flow-level bucket model and a per-cycle compare process.
module tb_irl_tb_meter;
  localparam int DN = 4, CN = 18, EN = 18, IN = 16, LN = 14, NF = 16;
  localparam int CMAX = (1 << CN) - 1, EMAX = (1 << EN) - 1;

  logic clk = 1'b0, rst_n = 1'b0, refill_tick = 1'b0, meter_req = 1'b0;
  logic [DN-1:0] meter_flow_id = '0;
  logic [LN-1:0] meter_len = '0;
  logic meter_valid, sweep_busy, sweep_overrun;
  logic [1:0] meter_color;
  logic token_bucket_rd, token_bucket_wr, fill_tb_src_rd;
  logic [DN-1:0] token_bucket_raddr, token_bucket_waddr, fill_tb_src_raddr;
  logic token_bucket_ack = 1'b0, fill_tb_src_ack = 1'b0;
  logic [CN+EN-1:0] token_bucket_rdata = '0, token_bucket_wdata;
  logic [2*IN-1:0] fill_tb_src_rdata = '0;
`ifdef IRL_COLOR_AWARE_EN
  logic [1:0] meter_color_in = 2'd0;
`endif

  irl_tb_meter #(.DEPTH_NBITS(DN), .CIR_TB_NBITS(CN), .EIR_TB_NBITS(EN),
                 .INC_NBITS(IN), .LEN_NBITS(LN)) dut (
    .clk(clk), .rst_n(rst_n), .refill_tick(refill_tick), .meter_req(meter_req),
    .meter_flow_id(meter_flow_id), .meter_len(meter_len),
`ifdef IRL_COLOR_AWARE_EN
    .meter_color_in(meter_color_in),
`endif
    .meter_valid(meter_valid), .meter_color(meter_color),
    .sweep_busy(sweep_busy), .sweep_overrun(sweep_overrun),
    .token_bucket_rd(token_bucket_rd), .token_bucket_raddr(token_bucket_raddr),
    .token_bucket_ack(token_bucket_ack), .token_bucket_rdata(token_bucket_rdata),
    .token_bucket_wr(token_bucket_wr), .token_bucket_waddr(token_bucket_waddr),
    .token_bucket_wdata(token_bucket_wdata),
    .fill_tb_src_rd(fill_tb_src_rd), .fill_tb_src_raddr(fill_tb_src_raddr),
    .fill_tb_src_ack(fill_tb_src_ack), .fill_tb_src_rdata(fill_tb_src_rdata));

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Memories: 1-cycle read latency, reads see pre-write contents.
  logic [CN+EN-1:0] mem [NF];
  logic [2*IN-1:0]  fill_mem [NF];
  int wr_cnt = 0;
  always @(posedge clk) begin
    token_bucket_ack <= token_bucket_rd;
    fill_tb_src_ack  <= fill_tb_src_rd;
    if (token_bucket_rd) token_bucket_rdata <= mem[token_bucket_raddr];
    if (fill_tb_src_rd)  fill_tb_src_rdata  <= fill_mem[fill_tb_src_raddr];
    if (token_bucket_wr) begin
      mem[token_bucket_waddr] <= token_bucket_wdata;
      wr_cnt++;
    end
  end

  // Flow-level model: operations take effect in issue order.
  int unsigned m_cir [NF], m_eir [NF];
  bit m_act = 0, m_ovr = 0, ev1 = 0, ev2 = 0, was_act;
  int m_ptr = 0, ec1 = 0, ec2 = 0, mf, ml;
  always @(posedge clk) begin
    was_act = m_act;
    ev2 = ev1; ec2 = ec1; ev1 = 0;
    if (rst_n) begin
      if (meter_req) begin
        mf = int'(meter_flow_id); ml = int'(meter_len); ev1 = 1;
        if (ml <= m_cir[mf]) begin ec1 = 0; m_cir[mf] -= ml; end
        else if (ml <= m_eir[mf]) begin ec1 = 1; m_eir[mf] -= ml; end
        else ec1 = 2;
      end else if (m_act) begin
        m_cir[m_ptr] = (m_cir[m_ptr] + fill_mem[m_ptr][2*IN-1:IN] > CMAX) ? CMAX
                     : m_cir[m_ptr] + fill_mem[m_ptr][2*IN-1:IN];
        m_eir[m_ptr] = (m_eir[m_ptr] + fill_mem[m_ptr][IN-1:0] > EMAX) ? EMAX
                     : m_eir[m_ptr] + fill_mem[m_ptr][IN-1:0];
        if (m_ptr == NF-1) m_act = 0;
        m_ptr++;
      end
      if (refill_tick) begin
        if (was_act) m_ovr = 1;
        else begin m_act = 1; m_ptr = 0; end
      end
    end
  end

  bit chk_en = 0;
  int busy_cnt = 0;
  int obs[$];
  always @(negedge clk) begin
    if (chk_en) begin
      check("meter_valid", meter_valid, ev2);
      if (ev2) check("meter_color", meter_color, ec2);
      check("sweep_busy", sweep_busy, m_act);
      check("sweep_overrun", sweep_overrun, m_ovr);
    end
    if (rst_n && meter_valid) obs.push_back(int'(meter_color));
    if (rst_n && sweep_busy) busy_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic set_flow(input int f, input int c, input int e);
    mem[f] <= {CN'(c), EN'(e)};
    m_cir[f] = c; m_eir[f] = e;
  endtask

  task automatic meter(input int f, input int l);
    meter_req = 1'b1; meter_flow_id = DN'(f); meter_len = LN'(l);
    cyc(1);
    meter_req = 1'b0;
  endtask

  task automatic check_mem();
    for (int f = 0; f < NF; f++) begin
      check("mem_cir", mem[f][CN+EN-1:EN], m_cir[f]);
      check("mem_eir", mem[f][EN-1:0], m_eir[f]);
    end
  endtask

  task automatic wait_sweep_done();
    for (int k = 0; k < 200 && sweep_busy; k++) cyc(1);
    check("sweep_done", sweep_busy, 0);
    cyc(3);
  endtask

  int unsigned snap_c, snap_e;

  initial begin
    #1;
    check("rst_meter_valid", meter_valid, 0);
    check("rst_meter_color", meter_color, 0);
    check("rst_sweep_busy", sweep_busy, 0);
    check("rst_overrun", sweep_overrun, 0);
    check("rst_tb_rd", token_bucket_rd, 0);
    check("rst_tb_wr", token_bucket_wr, 0);
    check("rst_fill_rd", fill_tb_src_rd, 0);
    for (int f = 0; f < NF; f++) begin
      set_flow(f, 1000 + 10 * f, 500);
      fill_mem[f] = {IN'(5), IN'(3)};
    end
    set_flow(5, 100, 50);
    set_flow(3, 10, 80);
    set_flow(7, CMAX - 3, 7);
    set_flow(9, 20, EMAX - 1);
    set_flow(4, 20, 20);
    set_flow(2, 30, 30);
    cyc(2);
    rst_n = 1'b1;
    chk_en = 1;
    cyc(2);

    // Back-to-back same flow: GREEN, then RED, RED via the bypassed value.
    obs.delete();
    meter_req = 1'b1; meter_flow_id = 4'd5; meter_len = 14'd60;
    cyc(3);
    meter_req = 1'b0;
    cyc(3);
    check("t1_count", obs.size(), 3);
    if (obs.size() == 3) begin
      check("t1_col0", obs[0], 0);
      check("t1_col1", obs[1], 2);
      check("t1_col2", obs[2], 2);
    end
    check("t1_cir5", mem[5][CN+EN-1:EN], 40);
    check("t1_eir5", mem[5][EN-1:0], 50);

    obs.delete();
    meter(3, 30);
    meter(2, 0);
    cyc(3);
    check("t2_count", obs.size(), 2);
    if (obs.size() == 2) begin
      check("t2_col_yellow", obs[0], 1);
      check("t2_col_len0", obs[1], 0);
    end
    check("t2_cir3", mem[3][CN+EN-1:EN], 10);
    check("t2_eir3", mem[3][EN-1:0], 50);
    check("t2_flow2", mem[2], {CN'(30), EN'(30)});

    // Plain sweep with saturation.
    wr_cnt = 0; busy_cnt = 0;
    refill_tick = 1'b1; cyc(1); refill_tick = 1'b0;
    wait_sweep_done();
    check("t3_busy_cycles", busy_cnt, 16);
    check("t3_writes", wr_cnt, 16);
    check("t3_cir7_sat", mem[7][CN+EN-1:EN], CMAX);
    check("t3_eir9_sat", mem[9][EN-1:0], EMAX);
    check("t3_cir0", mem[0][CN+EN-1:EN], 1005);
    check_mem();

    // Tick alongside a meter, then 10 meter cycles mid-sweep stall the pointer.
    busy_cnt = 0;
    refill_tick = 1'b1; meter_req = 1'b1; meter_flow_id = 4'd0; meter_len = 14'd1;
    cyc(1);
    refill_tick = 1'b0; meter_req = 1'b0;
    cyc(3);
    meter_req = 1'b1; meter_flow_id = 4'd2; meter_len = 14'd7;
    cyc(10);
    meter_req = 1'b0;
    wait_sweep_done();
    check("t4_busy_cycles", busy_cnt, 26);
    check("t4_cir2", mem[2][CN+EN-1:EN], 5);
    check("t4_eir2", mem[2][EN-1:0], 1);
    check_mem();

    // Second tick during a sweep: sticky overrun, no restart.
    busy_cnt = 0;
    refill_tick = 1'b1; cyc(1); refill_tick = 1'b0;
    cyc(3);
    refill_tick = 1'b1; cyc(1); refill_tick = 1'b0;
    check("t5_overrun_set", sweep_overrun, 1);
    wait_sweep_done();
    check("t5_busy_cycles", busy_cnt, 16);
    check("t5_overrun_held", sweep_overrun, 1);
    check_mem();

    // Reset in the stage-1 cycle of a meter op.
    snap_c = m_cir[4]; snap_e = m_eir[4];
    meter(4, 5);
    chk_en = 0;
    rst_n = 1'b0;
    #1;
    check("t6_no_wr", token_bucket_wr, 0);
    check("t6_meter_valid", meter_valid, 0);
    check("t6_meter_color", meter_color, 0);
    check("t6_busy", sweep_busy, 0);
    check("t6_overrun", sweep_overrun, 0);
    check("t6_tb_rd", token_bucket_rd, 0);
    m_cir[4] = snap_c; m_eir[4] = snap_e;
    ev1 = 0; ev2 = 0; m_act = 0; m_ovr = 0;
    cyc(2);
    check("t6_mem4_cir", mem[4][CN+EN-1:EN], 35);
    check("t6_mem4_eir", mem[4][EN-1:0], 29);
    rst_n = 1'b1;
    cyc(1);
    chk_en = 1;
    obs.delete();
    meter(4, 5);
    cyc(3);
    check("t6_post_count", obs.size(), 1);
    if (obs.size() == 1) check("t6_post_col", obs[0], 0);
    check("t6_post_cir4", mem[4][CN+EN-1:EN], 30);
    check_mem();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
